// File: rtl/mips_pkg.sv
// Constants shared by the decode stage and the register-bank dump controller.
package mips_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Read-port-A address mux select, driven into the decode stage.
    localparam logic SEL_DECODE = 1'b0;
    localparam logic SEL_DUMP   = 1'b1;

endpackage

// File: rtl/regbank_dump_controller.sv
// Freezes the pipeline, walks read port A over every register and streams
// the values out on a valid/ready port, then releases the pipeline.
module regbank_dump_controller
    import mips_pkg::*;
#(
    parameter int SIZE          = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_dump_req,
    input  logic                    i_pipe_empty,
    output logic                    o_stall,
    output logic                    o_dir_sel,
    output logic [SIZE_REG_DIR-1:0] o_dir_regA,
    input  logic [SIZE-1:0]         i_reg_A,
    output logic [SIZE-1:0]         o_data,
    output logic [SIZE_REG_DIR-1:0] o_index,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [SIZE_REG_DIR-1:0] LAST_IDX = SIZE_REG_DIR'(NUM_REGISTERS - 1);

    logic [2:0]              state;
    logic [SIZE_REG_DIR-1:0] count;
    logic                    handshake;

    assign handshake = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            o_data  <= '0;
            o_index <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_dump_req) begin
                        state <= ST_DRAIN;
                        count <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (i_pipe_empty) state <= ST_READ;
                end
                ST_READ: begin
                    o_data  <= i_reg_A;
                    o_index <= count;
                    o_valid <= 1'b1;
                    o_last  <= (count == LAST_IDX);
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        o_data  <= '0;
                        o_index <= '0;
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        // Terminal compare before increment keeps count in range.
                        if (count == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            count <= count + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_stall    = (state != ST_IDLE);
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);
    assign o_dir_sel  = (state == ST_READ || state == ST_SEND) ? SEL_DUMP : SEL_DECODE;
    assign o_dir_regA = (o_dir_sel == SEL_DUMP) ? count : '0;

endmodule

// File: tb/tb_regbank_dump_controller.sv
// Directed bench for the dump controller, with a beat-sequence scoreboard.
module tb_regbank_dump_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        dump_req = 1'b0, pipe_empty = 1'b1, ready = 1'b1;
    logic        stall, dir_sel, valid, last, busy, done;
    logic [4:0]  dir_regA, index;
    logic [31:0] reg_a, data;
    logic [31:0] bank [32];

    logic        req8 = 1'b0, pipe8 = 1'b1, ready8 = 1'b1;
    logic        stall8, dir_sel8, valid8, last8, busy8, done8;
    logic [2:0]  dir8, index8;
    logic [31:0] reg_a8, data8;
    logic [31:0] bank8 [8];

    assign reg_a  = bank[dir_regA];
    assign reg_a8 = bank8[dir8];

    regbank_dump_controller dut (
        .clk(clk), .rst(rst), .i_dump_req(dump_req), .i_pipe_empty(pipe_empty),
        .o_stall(stall), .o_dir_sel(dir_sel), .o_dir_regA(dir_regA), .i_reg_A(reg_a),
        .o_data(data), .o_index(index), .o_valid(valid), .i_ready(ready),
        .o_last(last), .o_busy(busy), .o_done(done)
    );

    regbank_dump_controller #(.SIZE(32), .NUM_REGISTERS(8)) dut8 (
        .clk(clk), .rst(rst), .i_dump_req(req8), .i_pipe_empty(pipe8),
        .o_stall(stall8), .o_dir_sel(dir_sel8), .o_dir_regA(dir8), .i_reg_A(reg_a8),
        .o_data(data8), .o_index(index8), .o_valid(valid8), .i_ready(ready8),
        .o_last(last8), .o_busy(busy8), .o_done(done8)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic wait_done(input int max);
        int i = 0;
        neg();
        while (!done && i < max) begin
            neg();
            i++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no o_done expected one within %0d cycles", max);
        end
    endtask

    task automatic wait_valid(input int max);
        int i = 0;
        neg();
        while (!valid && i < max) begin
            neg();
            i++;
        end
        if (!valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL valid_timeout: got no o_valid expected one within %0d cycles", max);
        end
    endtask

    // Scoreboard: beats must arrive as 0,1,2,... with bank data, held while stalled.
    int          exp_idx = 0, beats = 0, last_cnt = 0, stall_cnt = 0, last_stall = 0, done_cnt = 0;
    bit          hold = 1'b0;
    logic [31:0] hd;
    logic [4:0]  hi;
    always @(negedge clk) begin
        #4;
        if (rst) begin
            exp_idx = 0; beats = 0; last_cnt = 0; stall_cnt = 0; hold = 1'b0;
        end else begin
            if (stall) stall_cnt++;
            else stall_cnt = 0;
            if (hold) begin
                chk("hold_valid", valid, 1);
                chk("hold_data", data, hd);
                chk("hold_index", index, hi);
            end
            hold = valid && !ready;
            hd = data;
            hi = index;
            if (valid) chk("valid_ctl", {stall, busy, dir_sel}, 3'b111);
            if (valid && ready) begin
                chk("beat_index", index, exp_idx);
                chk("beat_data", data, bank[exp_idx[4:0]]);
                chk("beat_last", last, exp_idx == 31);
                if (last) last_cnt++;
                exp_idx++;
                beats++;
            end
            if (done) begin
                chk("done_beats", beats, 32);
                chk("done_last_cnt", last_cnt, 1);
                chk("done_no_valid", valid, 0);
                last_stall = stall_cnt;
                done_cnt++;
                exp_idx = 0; beats = 0; last_cnt = 0;
            end
        end
    end

    int exp8 = 0, last8_cnt = 0, done8_cnt = 0;
    always @(negedge clk) begin
        #4;
        if (rst) begin
            exp8 = 0; last8_cnt = 0;
        end else begin
            if (dir_sel8) chk("n8_addr_range", dir8 <= 3'd7 && dir8 == exp8[2:0], 1);
            if (valid8 && ready8) begin
                chk("n8_index", index8, exp8);
                chk("n8_data", data8, bank8[exp8[2:0]]);
                chk("n8_last", last8, exp8 == 7);
                if (last8) last8_cnt++;
                exp8++;
            end
            if (done8) begin
                chk("n8_beats", exp8, 8);
                chk("n8_last_cnt", last8_cnt, 1);
                done8_cnt++;
                exp8 = 0; last8_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = i * 32'h1111_1111;
        for (int i = 0; i < 8; i++) bank8[i] = i * 32'h0101_0101 + 32'hA0;

        // Reset and idle.
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) begin
            neg();
            chk("idle_ctl", {stall, busy, dir_sel, valid, last, done}, 0);
            chk("idle_bus", {data, index, dir_regA}, 0);
        end

        // Plain full dump, request pulse.
        tick(); dump_req = 1'b1;
        tick(); dump_req = 1'b0;
        neg(); chk("drain_state", {stall, dir_sel, valid}, 3'b100);
        tick(); neg(); chk("read0", {dir_sel, valid, dir_regA}, {1'b1, 1'b0, 5'd0});
        tick(); neg(); chk("first_beat", {valid, index, data}, {1'b1, 5'd0, 32'd0});
        wait_done(200);
        neg();
        chk("done_pulse", done, 0);
        chk("stall_66", last_stall, 66);
        chk("done_cnt1", done_cnt, 1);

        // Pipeline not empty for 10 cycles, then random i_pipe_empty during the walk.
        pipe_empty = 1'b0;
        tick(); dump_req = 1'b1;
        tick(); dump_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            neg(); chk("drain_hold", {stall, dir_sel, valid}, 3'b100);
            tick();
        end
        pipe_empty = 1'b1;
        neg(); chk("drain_last", {stall, dir_sel, valid}, 3'b100);
        tick(); neg(); chk("read_after_empty", {dir_sel, valid}, 2'b10);
        for (int i = 0; i < 300 && !done; i++) begin
            tick(); pipe_empty = 1'($urandom_range(0, 1));
            neg();
        end
        pipe_empty = 1'b1;
        neg();
        chk("stall_76", last_stall, 76);

        // Consumer stalls 5 cycles on beat 7; nonzero register 0.
        bank[0] = 32'hDEAD_BEEF;
        ready = 1'b0;
        tick(); dump_req = 1'b1;
        tick(); dump_req = 1'b0;
        for (int b = 0; b < 32; b++) begin
            wait_valid(10);
            chk("seq_index", index, b);
            if (b == 7) begin
                repeat (5) begin
                    tick(); neg();
                    chk("stall7_idx", {valid, index}, {1'b1, 5'd7});
                    chk("stall7_data", data, 32'h7777_7777);
                end
            end
            #1 ready = 1'b1;
            tick(); ready = 1'b0;
            if (b == 7) begin
                neg(); chk("no_early_beat8", valid, 0);
            end
        end
        wait_done(10);
        neg();
        chk("stall_71", last_stall, 71);
        ready = 1'b1;

        // Request held high: back-to-back dumps, mid-dump requests ignored.
        tick(); dump_req = 1'b1;
        wait_done(100);
        neg(); chk("idle_gap", {stall, busy}, 2'b00);
        neg(); chk("restart", {stall, dir_sel}, 2'b10);
        tick(); dump_req = 1'b0;
        repeat (10) tick();
        dump_req = 1'b1;
        tick(); dump_req = 1'b0;
        wait_done(100);
        neg();
        chk("stall_2nd", last_stall, 66);
        chk("done_cnt5", done_cnt, 5);
        repeat (3) neg();
        chk("stays_idle", {busy, stall}, 2'b00);

        // Reset in the middle of SEND.
        ready = 1'b0;
        tick(); dump_req = 1'b1;
        tick(); dump_req = 1'b0;
        wait_valid(10);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        neg(); chk("rst_midsend", {valid, stall, busy}, 3'b000);
        ready = 1'b1;

        // Eight-register build.
        tick(); req8 = 1'b1;
        tick(); req8 = 1'b0;
        begin
            int i = 0;
            neg();
            while (!done8 && i < 100) begin
                neg();
                i++;
            end
        end
        neg();
        chk("n8_done_cnt", done8_cnt, 1);
        chk("n8_idle", {busy8, valid8}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_dump_controller.md
# regbank_dump_controller

Sequencer that shares the decode stage's register bank read port A between normal instruction decode and a debug dump path. On request, it freezes the pipeline and waits for it to drain. It then walks register addresses 0..NUM_REGISTERS-1 through read port A and streams each value out over a valid/ready interface, then releases the pipeline. It sits beside the decode stage and drives the select of the read-port-A address mux and the pipeline stall line.

## Interface
Parameters:
- SIZE, 32, data width of a register
- NUM_REGISTERS, 32, number of registers dumped
- SIZE_REG_DIR, $clog2(NUM_REGISTERS), register address width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_dump_req  in  1  dump request; level or pulse, sampled in IDLE only
- i_pipe_empty  in  1  high when no instruction is in flight past decode and no writeback is pending
- o_stall  out  1  freezes fetch/decode while high
- o_dir_sel  out  1  1 = read port A address comes from o_dir_regA, 0 = from instruction rs field
- o_dir_regA  out  SIZE_REG_DIR  dump read address
- i_reg_A  in  SIZE  register bank read port A data (combinational read)
- o_data  out  SIZE  dumped register value
- o_index  out  SIZE_REG_DIR  address of o_data
- o_valid  out  1  o_data/o_index valid
- i_ready  in  1  consumer accepts when o_valid && i_ready
- o_last  out  1  high with o_valid for index NUM_REGISTERS-1
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at dump completion

## Operation
- States: IDLE, DRAIN, READ, SEND, DONE.
- IDLE:
  - all outputs 0.
  - i_dump_req=1 → DRAIN; count cleared to 0.
- DRAIN:
  - o_stall=1, o_busy=1.
  - i_pipe_empty=1 → READ; otherwise stay.
- READ:
  - o_dir_sel=1, o_dir_regA=count.
  - i_reg_A is captured into o_data and count into o_index at the end of the cycle.
  - → SEND with o_valid=1.
- SEND:
  - o_data, o_index, o_valid and o_last are held stable until the handshake.
  - o_dir_sel stays 1.
  - On handshake: if count==NUM_REGISTERS-1 → DONE; else count+1 → READ.
  - No handshake → stay.
- DONE:
  - o_done=1, o_stall=1 for this cycle.
  - → IDLE, where o_stall falls.
- i_dump_req outside IDLE is ignored; a request still high when IDLE is re-entered starts a new dump.
- count is SIZE_REG_DIR bits and never wraps: the terminal compare happens before any increment.
- o_valid never drops without a handshake, except on rst.
- Register 0 is dumped as whatever the bank returns; the controller does not force zero.

## Timing
- All outputs are registered and decoded from state/count; no combinational input-to-output paths.
- Reset values: state IDLE, count 0, all outputs 0.
- rst sampled high in any state → IDLE next edge. A pending o_valid is dropped with no handshake, and o_stall falls.
- Request sampled at edge k → o_stall=1 from edge k+1.
- With i_pipe_empty already high, the first READ occurs at cycle k+2 and the first o_valid at k+3.
- Each register costs 2 cycles (READ + SEND) with i_ready held high.
- Full dump for 32 registers: 1 DRAIN + 64 + 1 DONE = 66 cycles of o_stall.
- i_ready low stretches SEND indefinitely; READ is never repeated for the same index.
- i_pipe_empty toggling during READ/SEND has no effect; it is only sampled in DRAIN.

## Structure
- Shared package (mips_pkg) holds:
  - the state encoding as localparams: IDLE=0, DRAIN=1, READ=2, SEND=3, DONE=4, in 3 bits;
  - the o_dir_sel encoding constants (SEL_DECODE=0, SEL_DUMP=1), shared with the decode stage.
- No sub-module is needed. The read-port-A address selection stays in the decode stage, using the existing mux module driven by o_dir_sel.

## Test plan
- Reset, then hold everything idle → every output stays 0. Mid-SEND rst → o_valid, o_stall and o_busy are 0 the next cycle.
- Bank preloaded with reg[i]=i*0x11111111, i_pipe_empty=1, i_ready=1, dump_req pulse:
  - 32 beats arrive in order with index 0..31 and matching data;
  - o_last only on index 31;
  - o_done one cycle;
  - o_stall high exactly 66 cycles.
- i_pipe_empty held 0 for 10 cycles after the request → stays in DRAIN, o_stall=1, no o_valid. First READ occurs one cycle after i_pipe_empty rises.
- i_ready driven low for 5 cycles on beat 7 → o_data and o_index=7 stay stable. Beat 8 appears only after the handshake. No beats are skipped or duplicated.
- i_dump_req held high continuously → second dump starts immediately after DONE (IDLE one cycle, o_stall low one cycle). Requests raised mid-dump do not restart the count.
- NUM_REGISTERS=8 build → indices 0..7, o_last on 7, count never exceeds 7.
